aes_inv_round_engine: RTL and testbench
=======================================

# aes_inv_round_engine

Parametrised, registered AES-128 inverse-cipher round with a valid/ready handshake. It executes one decryption round per transaction and is selectable as initial, middle or final round. InvSubBytes runs over a configurable number of S-box lanes, which trades area against latency. It is the sequential successor to the purely combinational inverse initial round and slots into the iterative decrypt datapath between the round-key schedule and the round controller.

## Interface
- LANES, 16, inverse S-boxes instantiated; legal values 1, 2, 4, 8, 16; any other value is an elaboration error
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- in_valid  input  1  state_in/round_key/mode valid
- in_ready  output  1  engine can accept a block
- mode  input  2  0=INIT (ARK→ISR→ISB), 1=MID (ARK→IMC→ISR→ISB), 2=FINAL (ARK only), 3=treated as FINAL
- round_key  input  128  round key for this round
- state_in  input  128  state, byte i = bits [127-8i -: 8], column-major per FIPS-197
- out_valid  output  1  state_out valid
- out_ready  input  1  downstream accepts state_out
- state_out  output  128  round result

## Operation
- FSM states: IDLE, SUB, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid: work ← ISR(IMC?(state_in ^ round_key)), with IMC applied only in MID; ARK only for FINAL/3.
  - mode is latched, cnt ← 0.
  - Next state is DONE if mode is FINAL/3, otherwise SUB.
- **SUB**
  - in_ready=0.
  - Each cycle, bytes cnt·LANES … cnt·LANES+LANES−1 of work ← InvSBox(byte); cnt++.
  - After group 16/LANES−1 completes, next state is DONE.
  - Inputs are ignored.
- **DONE**
  - out_valid=1 and state_out=work, both held stable until out_ready.
  - On out_ready, next state is IDLE.
  - No new block is accepted in DONE; in_ready is asserted only in IDLE.
- **Arithmetic**
  - ISR: row r rotates right by r byte positions.
  - IMC: per-column GF(2^8) multiply by {0e,0b,0d,09} matrix, polynomial 0x11B.
  - cnt width is clog2(16/LANES), minimum 1 bit.
- state_out is driven only from work. It is never combinational from inputs.

## Timing
- Reset (reset=0 at a rising edge) forces: IDLE, in_ready=1 on the following cycle, out_valid=0, state_out=0, work=0, cnt=0.
- Reset mid-SUB or mid-DONE abandons the block. No partial result appears.
- Latency is counted from the accept edge to the first cycle with out_valid=1:
  - FINAL: 1 cycle.
  - INIT/MID: 1 + 16/LANES cycles, i.e. 2 for LANES=16 and 17 for LANES=1.
- Minimum initiation interval is latency + 1 cycles with out_ready tied high.
- out_ready held low stalls indefinitely in DONE with state_out unchanged.
- out_ready asserted in IDLE or SUB has no effect.
- in_valid with in_ready=0 has no effect. The source must hold the data; the engine does not latch it.

## Test plan
- **Reset values:** reset low 3 cycles, then high -> in_ready=1, out_valid=0, state_out=0.
- **INIT vector, all legal LANES:**
  - Stimulus: mode=0, state_in=69c4e0d86a7b0430d8cdb78070b4c55a, round_key=13111d7fe3944a17f307a78b4d2b30c5.
  - Required: state_out=bd6e7c3df2b5779e0b61216e8b10b689 with out_valid exactly 1+16/LANES cycles after accept.
- **MID zero vector:** mode=1, state_in=0, round_key=0 -> state_out=52525252…52 (all 16 bytes 0x52). Then state_in=round_key=63636363…63 gives all-zero ARK, so state_out=52…52 again.
- **FINAL vector:**
  - Stimulus: mode=2, state_in=00102030405060708090a0b0c0d0e0f0, round_key=000102030405060708090a0b0c0d0e0f.
  - Required: state_out=00112233445566778899aabbccddeeff, 1 cycle after accept; mode=3 gives an identical result.
- **Back-pressure:**
  - Hold out_ready=0 for 10 cycles in DONE -> out_valid and state_out stable, in_ready=0.
  - A second in_valid pulse during the stall is not accepted.
  - out_ready=1 -> IDLE next cycle.
- **Reset mid-operation:** LANES=1, reset low at the 5th SUB cycle -> next cycle out_valid=0 and state_out=0. A fresh INIT vector afterwards produces the correct result.

Source files
------------

// File: rtl/aes_inv_round_engine.sv
// AES-128 inverse-cipher round engine: ARK / InvMixColumns / InvShiftRows on accept,
// then InvSubBytes over LANES S-boxes per cycle, with a valid/ready handshake on both sides.
module aes_inv_round_engine #(
  parameter int LANES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   mode,
  input  logic [127:0] round_key,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  localparam int GROUPS = 16 / LANES;
  localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("aes_inv_round_engine: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  // Byte i of the FIPS-197 byte stream lives at packed index 15-i.
  typedef logic [15:0][7:0] blk_t;

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  state_t        state;
  blk_t          work;
  logic [CW-1:0] cnt;
  blk_t          front;
  blk_t          sub_work;

  function automatic logic [3:0] ix(input int unsigned i);
    return 4'(15 - i);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] aa;
    r  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  // Inverse affine transform, then multiplicative inverse as x^254 (maps 0 to 0).
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] a;
    logic [7:0] p;
    logic [7:0] r;
    a = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    p = a;
    r = 8'h01;
    for (int unsigned i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic blk_t inv_shift_rows(input blk_t a);
    blk_t o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[ix(r + 4 * ((c + r) % 4))] = a[ix(r + 4 * c)];
      end
    end
    return o;
  endfunction

  function automatic blk_t inv_mix_columns(input blk_t a);
    blk_t o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[ix(4 * c + r)] = gf_mul(8'h0e, a[ix(4 * c + r)])
                         ^ gf_mul(8'h0b, a[ix(4 * c + (r + 1) % 4)])
                         ^ gf_mul(8'h0d, a[ix(4 * c + (r + 2) % 4)])
                         ^ gf_mul(8'h09, a[ix(4 * c + (r + 3) % 4)]);
      end
    end
    return o;
  endfunction

  always_comb begin
    blk_t ark;
    ark   = state_in ^ round_key;
    front = ark;
    case (mode)
      2'd0:    front = inv_shift_rows(ark);
      2'd1:    front = inv_shift_rows(inv_mix_columns(ark));
      default: front = ark;
    endcase
  end

  always_comb begin
    sub_work = work;
    for (int unsigned l = 0; l < LANES; l++) begin
      sub_work[ix(int'(cnt) * LANES + l)] = inv_sbox(work[ix(int'(cnt) * LANES + l)]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      work      <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= front;
            cnt      <= '0;
            in_ready <= 1'b0;
            if (mode[1]) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= SUB;
            end
          end
        end
        SUB: begin
          work <= sub_work;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(GROUPS - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign state_out = work;

endmodule

// File: tb/tb_aes_inv_round_engine.sv
// Directed bench for aes_inv_round_engine: one instance per legal LANES value sharing stimulus,
// FIPS-197 inverse-cipher vectors, back-pressure stall and mid-operation reset.
module tb_aes_inv_round_engine;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [1:0]   mode;
  logic [127:0] round_key;
  logic [127:0] state_in;
  logic         out_ready;
  logic [4:0]   in_ready_v;
  logic [4:0]   out_valid_v;
  logic [127:0] state_out_v [5];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  // Instance g has LANES = 2**g.
  for (genvar g = 0; g < 5; g++) begin : g_dut
    aes_inv_round_engine #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready_v[g]),
      .mode      (mode),
      .round_key (round_key),
      .state_in  (state_in),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready),
      .state_out (state_out_v[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered just after a negedge with every instance idle and out_ready high.
  task automatic run_txn(input string tag, input logic [1:0] m, input logic [127:0] s,
                         input logic [127:0] k, input logic [127:0] exp);
    int          first [5];
    logic [127:0] got  [5];
    for (int g = 0; g < 5; g++) begin
      first[g] = 0;
      got[g]   = '0;
    end
    mode      = m;
    state_in  = s;
    round_key = k;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      for (int g = 0; g < 5; g++) begin
        if (out_valid_v[g] === 1'b1 && first[g] == 0) begin
          first[g] = c;
          got[g]   = state_out_v[g];
        end
      end
      @(negedge clk);
    end
    for (int g = 0; g < 5; g++) begin
      check($sformatf("%s_lat_L%0d", tag, 1 << g), 128'(first[g]),
            128'((m[1] ? 1 : 1 + (16 >> g))));
      check($sformatf("%s_data_L%0d", tag, 1 << g), got[g], exp);
    end
  endtask

  localparam logic [127:0] INIT_S = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] INIT_K = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] INIT_E = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
  localparam logic [127:0] MID_K  = 128'h549932d1f08557681093ed9cbe2c974e;
  localparam logic [127:0] MID_E  = 128'hfde3bad205e5d0d73547964ef1fe37f1;
  localparam logic [127:0] FIN_S  = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] FIN_K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIN_E  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] ALL52  = {16{8'h52}};
  localparam logic [127:0] ALL63  = {16{8'h63}};

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    mode      = 2'd0;
    round_key = '0;
    state_in  = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 5; g++) begin
      check($sformatf("rst_in_ready_L%0d", 1 << g), 128'(in_ready_v[g]), 128'(1));
      check($sformatf("rst_out_valid_L%0d", 1 << g), 128'(out_valid_v[g]), 128'(0));
      check($sformatf("rst_state_out_L%0d", 1 << g), state_out_v[g], '0);
    end

    run_txn("init", 2'd0, INIT_S, INIT_K, INIT_E);
    run_txn("mid_zero", 2'd1, '0, '0, ALL52);
    run_txn("mid_63", 2'd1, ALL63, ALL63, ALL52);
    run_txn("mid_fips", 2'd1, INIT_E, MID_K, MID_E);
    run_txn("final2", 2'd2, FIN_S, FIN_K, FIN_E);
    run_txn("final3", 2'd3, FIN_S, FIN_K, FIN_E);

    // Back-pressure: stall in DONE, with a rejected in_valid pulse mid-stall.
    out_ready = 1'b0;
    mode      = 2'd2;
    state_in  = FIN_S;
    round_key = FIN_K;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      for (int g = 0; g < 5; g++) begin
        check($sformatf("bp_valid_L%0d_c%0d", 1 << g, i), 128'(out_valid_v[g]), 128'(1));
        check($sformatf("bp_data_L%0d_c%0d", 1 << g, i), state_out_v[g], FIN_E);
        check($sformatf("bp_ready_L%0d_c%0d", 1 << g, i), 128'(in_ready_v[g]), 128'(0));
      end
      if (i == 4) begin
        mode     = 2'd2;
        state_in = '1;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 5; g++) begin
      check($sformatf("bp_release_ready_L%0d", 1 << g), 128'(in_ready_v[g]), 128'(1));
      check($sformatf("bp_release_valid_L%0d", 1 << g), 128'(out_valid_v[g]), 128'(0));
    end
    repeat (3) begin
      @(negedge clk);
      for (int g = 0; g < 5; g++)
        check($sformatf("bp_no_stale_L%0d", 1 << g), 128'(out_valid_v[g]), 128'(0));
    end

    // Reset during the 5th SUB cycle of the LANES=1 instance.
    mode      = 2'd0;
    state_in  = INIT_S;
    round_key = INIT_K;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_rst_busy_L1", 128'(in_ready_v[0]), 128'(0));
    check("mid_rst_pre_valid_L1", 128'(out_valid_v[0]), 128'(0));
    reset = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 5; g++) begin
      check($sformatf("mid_rst_valid_L%0d", 1 << g), 128'(out_valid_v[g]), 128'(0));
      check($sformatf("mid_rst_data_L%0d", 1 << g), state_out_v[g], '0);
    end
    reset = 1'b1;
    @(negedge clk);
    run_txn("post_rst_init", 2'd0, INIT_S, INIT_K, INIT_E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
